csr_inst_loader: RTL

// - CSR-bus initiator that programs the instruction memory through the core's CSR register file.
// - Consumes a valid/ready instruction stream and drives the write sequence on the CSR request port:

---
 rtl/csr_inst_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/csr_inst_loader.sv
// CSR-bus initiator that streams instruction words into instruction memory through the CSR file.
// Define CSR_INST_LOADER_VERIFY_EN to read back and compare every word after it is written.
module csr_inst_loader #(
  parameter int unsigned CsrDataWidth = 32,
  parameter int unsigned CsrAddrWidth = 32,
  parameter int unsigned InstMemDepth = 1024,
  localparam int unsigned IdxW = $clog2(InstMemDepth) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [IdxW-1:0]         num_inst_i,
  input  logic                    start_core_i,
  input  logic [CsrDataWidth-1:0] inst_data_i,
  input  logic                    inst_valid_i,
  output logic                    inst_ready_o,
  output logic [CsrAddrWidth-1:0] csr_req_addr_o,
  output logic [CsrDataWidth-1:0] csr_req_data_o,
  output logic                    csr_req_write_o,
  output logic                    csr_req_valid_o,
  input  logic                    csr_req_ready_i,
  input  logic [CsrDataWidth-1:0] csr_rsp_data_i,
  input  logic                    csr_rsp_valid_i,
  output logic                    csr_rsp_ready_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam logic [CsrAddrWidth-1:0] CoreSetRegAddr       = CsrAddrWidth'(0);
  localparam logic [CsrAddrWidth-1:0] InstCtrlRegAddr      = CsrAddrWidth'(3);
  localparam logic [CsrAddrWidth-1:0] InstWriteAddrRegAddr = CsrAddrWidth'(4);
  localparam logic [CsrAddrWidth-1:0] InstWriteDataRegAddr = CsrAddrWidth'(5);
  localparam int unsigned InstCtrlWriteModeBit = 0;
  localparam int unsigned CoreSetStartCoreBit  = 0;
`ifdef CSR_INST_LOADER_VERIFY_EN
  localparam logic [CsrAddrWidth-1:0] InstRddbgAddrRegAddr     = CsrAddrWidth'(6);
  localparam logic [CsrAddrWidth-1:0] InstInstAtAddrAddrRegAddr = CsrAddrWidth'(7);
  localparam int unsigned InstCtrlDbgModeBit = 1;
`endif

  typedef enum logic [3:0] {
    StIdle, StSetWm, StWrAddr, StFetch, StWrData, StRdAddr, StRdData, StClrWm, StStart, StDone
  } state_e;

  state_e                  state_q, state_d;
  logic                    wait_q, wait_d;  // request accepted, response outstanding
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [IdxW-1:0]         num_q, num_d;
  logic                    start_core_q, start_core_d;
  logic [CsrDataWidth-1:0] word_q, word_d;
  logic                    err_q, err_d;
  logic                    req_state, rsp_hs, last_word;

  assign req_state = state_q inside {StSetWm, StWrAddr, StWrData, StRdAddr, StRdData, StClrWm,
                                     StStart};
  assign csr_req_valid_o = req_state & ~wait_q;
  assign csr_rsp_ready_o = req_state & wait_q;
  assign rsp_hs          = csr_rsp_ready_o & csr_rsp_valid_i;
  assign last_word       = (idx_q + IdxW'(1)) == num_q;
  assign busy_o          = (state_q != StIdle) && (state_q != StDone);
  assign done_o          = state_q == StDone;
  assign err_o           = err_q;

`ifdef CSR_INST_LOADER_VERIFY_EN
  assign csr_req_write_o = req_state && (state_q != StRdData);
`else
  assign csr_req_write_o = 1'b1;
  logic unused_rsp_data;
  assign unused_rsp_data = ^csr_rsp_data_i;
`endif

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    idx_d          = idx_q;
    num_d          = num_q;
    start_core_d   = start_core_q;
    word_d         = word_q;
    err_d          = err_q;
    inst_ready_o   = 1'b0;
    csr_req_addr_o = '0;
    csr_req_data_o = '0;

    if (csr_req_valid_o && csr_req_ready_i) wait_d = 1'b1;
    if (rsp_hs) wait_d = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_i) begin
          num_d        = num_inst_i;
          start_core_d = start_core_i;
          idx_d        = '0;
          wait_d       = 1'b0;
          err_d        = 1'b0;
          if (num_inst_i > IdxW'(InstMemDepth)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (num_inst_i == '0) begin
            state_d = StDone;
          end else begin
            state_d = StSetWm;
          end
        end
      end
      StSetWm: begin
        csr_req_addr_o                       = InstCtrlRegAddr;
        csr_req_data_o[InstCtrlWriteModeBit] = 1'b1;
`ifdef CSR_INST_LOADER_VERIFY_EN
        csr_req_data_o[InstCtrlDbgModeBit]   = 1'b1;
`endif
        if (rsp_hs) state_d = StWrAddr;
      end
      StWrAddr: begin
        csr_req_addr_o = InstWriteAddrRegAddr;
        csr_req_data_o = CsrDataWidth'(idx_q);
        if (rsp_hs) state_d = StFetch;
      end
      StFetch: begin
        inst_ready_o = 1'b1;
        if (inst_valid_i) begin
          word_d  = inst_data_i;
          state_d = StWrData;
        end
      end
      StWrData: begin
        csr_req_addr_o = InstWriteDataRegAddr;
        csr_req_data_o = word_q;
        if (rsp_hs) begin
`ifdef CSR_INST_LOADER_VERIFY_EN
          state_d = StRdAddr;
`else
          idx_d   = idx_q + IdxW'(1);
          state_d = last_word ? StClrWm : StWrAddr;
`endif
        end
      end
`ifdef CSR_INST_LOADER_VERIFY_EN
      StRdAddr: begin
        csr_req_addr_o = InstRddbgAddrRegAddr;
        csr_req_data_o = CsrDataWidth'(idx_q);
        if (rsp_hs) state_d = StRdData;
      end
      StRdData: begin
        csr_req_addr_o = InstInstAtAddrAddrRegAddr;
        if (rsp_hs) begin
          if (csr_rsp_data_i != word_q) begin
            // Abandon remaining words and suppress the core start
            err_d   = 1'b1;
            state_d = StClrWm;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = last_word ? StClrWm : StWrAddr;
          end
        end
      end
`endif
      StClrWm: begin
        csr_req_addr_o = InstCtrlRegAddr;
        if (rsp_hs) state_d = (start_core_q && !err_q) ? StStart : StDone;
      end
      StStart: begin
        csr_req_addr_o                      = CoreSetRegAddr;
        csr_req_data_o[CoreSetStartCoreBit] = 1'b1;
        if (rsp_hs) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      wait_q       <= 1'b0;
      idx_q        <= '0;
      num_q        <= '0;
      start_core_q <= 1'b0;
      word_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      idx_q        <= idx_d;
      num_q        <= num_d;
      start_core_q <= start_core_d;
      word_q       <= word_d;
      err_q        <= err_d;
    end
  end

endmodule
